// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline types: stage-register states and boundary payloads
package riscv_pkg;

  localparam int PIPE_CNT_W = 2;

  // Occupancy states of a pipeline stage register; encoding equals entry count
  typedef enum logic [PIPE_CNT_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_st_t;

  // Packed payloads carried across the classic pipeline boundaries
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [4:0]  rd;
    logic        we;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] data_b;
    logic [4:0]  rd;
    logic        we;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        we;
  } mem_wb_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register, skid or pass-ready mode
module pipe_stage_reg
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit SKID  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  up_valid,
  input  logic [WIDTH-1:0]      up_data,
  output logic                  up_ready,
  output logic                  dn_valid,
  output logic [WIDTH-1:0]      dn_data,
  input  logic                  dn_ready,
  output logic [PIPE_CNT_W-1:0] count
);

  if (SKID) begin : g_skid
    pipe_st_t         state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             rdy_q;
    logic             up_acc;
    logic             dn_acc;

    // up_ready comes straight from rdy_q, so dn_ready never reaches it combinationally
    assign up_acc   = up_valid && rdy_q;
    assign dn_acc   = (state != EMPTY) && dn_ready;
    assign up_ready = rdy_q;
    assign dn_valid = (state != EMPTY);
    assign dn_data  = main_q;
    assign count    = state;

    // Two-entry skid FSM; vacated entries are zeroed so dn_data is 0 when idle
    always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
        state  <= EMPTY;
        main_q <= '0;
        skid_q <= '0;
        rdy_q  <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (up_acc) begin
              main_q <= up_data;
              state  <= ONE;
            end
          end
          ONE: begin
            if (up_acc && dn_acc) begin
              main_q <= up_data;
            end else if (up_acc) begin
              skid_q <= up_data;
              state  <= TWO;
              rdy_q  <= 1'b0;
            end else if (dn_acc) begin
              main_q <= '0;
              state  <= EMPTY;
            end
          end
          TWO: begin
            if (dn_acc) begin
              main_q <= skid_q;
              skid_q <= '0;
              state  <= ONE;
              rdy_q  <= 1'b1;
            end
          end
          default: begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            rdy_q  <= 1'b1;
          end
        endcase
      end
    end
  end else begin : g_pass
    logic             valid_q;
    logic [WIDTH-1:0] main_q;
    logic             up_acc;
    logic             dn_acc;

    // Single entry may be refilled in the same cycle it is consumed
    assign up_ready = !valid_q || dn_ready;
    assign up_acc   = up_valid && up_ready;
    assign dn_acc   = valid_q && dn_ready;
    assign dn_valid = valid_q;
    assign dn_data  = main_q;
    assign count    = {1'b0, valid_q};

    // One-entry register; payload is cleared whenever the entry empties
    always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
        valid_q <= 1'b0;
        main_q  <= '0;
      end else if (up_acc) begin
        valid_q <= 1'b1;
        main_q  <= up_data;
      end else if (dn_acc) begin
        valid_q <= 1'b0;
        main_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for skid and pass-mode stage registers
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush    [2];
  logic        up_valid [2];
  logic [31:0] up_data  [2];
  logic        up_ready [2];
  logic        dn_valid [2];
  logic [31:0] dn_data  [2];
  logic        dn_ready [2];
  logic [1:0]  count    [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b1)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .up_valid(up_valid[0]), .up_data(up_data[0]), .up_ready(up_ready[0]),
    .dn_valid(dn_valid[0]), .dn_data(dn_data[0]), .dn_ready(dn_ready[0]),
    .count(count[0])
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b0)) u_pass (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .up_valid(up_valid[1]), .up_data(up_data[1]), .up_ready(up_ready[1]),
    .dn_valid(dn_valid[1]), .dn_data(dn_data[1]), .dn_ready(dn_ready[1]),
    .count(count[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-instance scoreboard: the queue holds exactly the entries the stage should own
  for (genvar k = 0; k < 2; k++) begin : g_sb
    logic [31:0] exq[$];
    bit          started = 1'b0;

    always @(posedge clk) begin
      bit          rdy;
      bit          pop;
      bit          push;
      logic [31:0] d;
      started = 1'b1;
      if (!rst_n || flush[k]) begin
        exq.delete();
      end else begin
        rdy  = (k == 0) ? (exq.size() < 2) : (exq.size() == 0 || dn_ready[k]);
        pop  = (exq.size() > 0) && dn_ready[k];
        push = up_valid[k] && rdy;
        d    = up_data[k];
        if (pop) void'(exq.pop_front());
        if (push) exq.push_back(d);
      end
    end

    always @(negedge clk) begin
      logic [31:0] exp_d;
      bit          exp_r;
      if (started) begin
        exp_d = (exq.size() > 0) ? exq[0] : 32'h0;
        exp_r = (k == 0) ? (exq.size() < 2) : (exq.size() == 0 || dn_ready[k]);
        chk($sformatf("inst%0d dn_valid", k), {31'b0, dn_valid[k]}, {31'b0, exq.size() > 0});
        chk($sformatf("inst%0d dn_data", k), dn_data[k], exp_d);
        chk($sformatf("inst%0d count", k), {30'b0, count[k]}, exq.size());
        chk($sformatf("inst%0d up_ready", k), {31'b0, up_ready[k]}, {31'b0, exp_r});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      flush[k] = 1'b0; up_valid[k] = 1'b0; up_data[k] = '0; dn_ready[k] = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] pd;
    rst_n = 1'b0;
    idle_all();
    step(); step();
    chk("reset s count", {30'b0, count[0]}, 0);
    chk("reset s up_ready", {31'b0, up_ready[0]}, 1);
    chk("reset p up_ready", {31'b0, up_ready[1]}, 1);
    chk("reset s dn_data", dn_data[0], 0);
    rst_n = 1'b1;

    // streaming 1..8 through skid instance
    dn_ready[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up_valid[0] = 1'b1; up_data[0] = i;
      chk("stream up_ready", {31'b0, up_ready[0]}, 1);
      step();
      chk("stream latency", dn_data[0], i);
    end
    up_valid[0] = 1'b0; up_data[0] = '0;
    step();
    chk("bubble dn_valid", {31'b0, dn_valid[0]}, 0);
    chk("bubble dn_data", dn_data[0], 0);

    // backpressure A, B, C
    dn_ready[0] = 1'b0;
    up_valid[0] = 1'b1; up_data[0] = 32'hA; step();
    up_data[0] = 32'hB; step();
    chk("bp count", {30'b0, count[0]}, 2);
    chk("bp up_ready", {31'b0, up_ready[0]}, 0);
    up_data[0] = 32'hC; step(); step();
    chk("bp hold main", dn_data[0], 32'hA);
    dn_ready[0] = 1'b1; step();
    chk("bp release B", dn_data[0], 32'hB);
    step();
    chk("bp C accepted", dn_data[0], 32'hC);
    up_valid[0] = 1'b0; step(); step();

    // flush while TWO with a transfer offered
    dn_ready[0] = 1'b0;
    up_valid[0] = 1'b1; up_data[0] = 32'h11; step();
    up_data[0] = 32'h22; step();
    flush[0] = 1'b1; up_data[0] = 32'h33; step();
    flush[0] = 1'b0; up_valid[0] = 1'b0;
    chk("flush count", {30'b0, count[0]}, 0);
    chk("flush dn_data", dn_data[0], 0);
    dn_ready[0] = 1'b1; step(); step();

    // flush from ONE: ready stays high, transfer discarded; held flush keeps EMPTY
    dn_ready[0] = 1'b0;
    up_valid[0] = 1'b1; up_data[0] = 32'h44; step();
    flush[0] = 1'b1; up_data[0] = 32'h55;
    chk("flush ONE up_ready", {31'b0, up_ready[0]}, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush held count", {30'b0, count[0]}, 0);
    end
    flush[0] = 1'b0; up_valid[0] = 1'b0; step();

    // reset during TWO
    up_valid[0] = 1'b1; up_data[0] = 32'h61; step();
    up_data[0] = 32'h62; step();
    up_valid[0] = 1'b0; rst_n = 1'b0; step();
    rst_n = 1'b1;
    chk("midrst dn_valid", {31'b0, dn_valid[0]}, 0);
    chk("midrst up_ready", {31'b0, up_ready[0]}, 1);
    dn_ready[0] = 1'b1; up_valid[0] = 1'b1; up_data[0] = 32'h77; step();
    chk("midrst 0x77", dn_data[0], 32'h77);
    up_valid[0] = 1'b0; step();

    // pass mode with toggling dn_ready and continuous input
    pd = 32'h5;
    for (int i = 0; i < 12; i++) begin
      dn_ready[1] = (i % 2 == 0);
      up_valid[1] = 1'b1; up_data[1] = pd;
      #1;
      if (up_ready[1]) pd = pd + 1;
      step();
    end
    up_valid[1] = 1'b0; dn_ready[1] = 1'b1; step(); step();

    // random traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        up_valid[k] = ($urandom_range(0, 3) != 0);
        dn_ready[k] = ($urandom_range(0, 2) != 0);
        flush[k]    = ($urandom_range(0, 19) == 0);
        up_data[k]  = $urandom;
      end
      step();
    end
    idle_all();
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
